// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package dmem_arb_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam int N_REQ      = 2;

   // The requester id doubles as the index into the per-requester vectors.
   typedef enum logic {
      REQ_CORE = 1'b0,
      REQ_DMA  = 1'b1
   } req_id_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      STALL = 2'd1,
      RESP  = 2'd2
   } state_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin selector: on a tie the requester that did not win last
// time is granted. Grant is one-hot or zero.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      // NOTE: default assigned first so every path drives gnt and no latch is inferred.
      gnt = 2'b00;
      if (req[0] && req[1]) begin
         gnt = last ? 2'b01 : 2'b10;
      end else begin
         gnt = req;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Core/DMA arbiter for a single-ported data memory: 1-cycle loads, posted stores
// through one write stage. Define DMEM_ARB_FWD_EN to forward from the write stage.
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,

   input  logic              core_req,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic              core_gnt,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,

   input  logic              dma_req,
   input  logic              dma_we,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [DATA_W-1:0] dma_wdata,
   output logic              dma_gnt,
   output logic              dma_rvalid,
   output logic [DATA_W-1:0] dma_rdata,

   output logic [ADDR_W-1:0] mem_rd_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [ADDR_W-1:0] mem_wr_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   output logic              mem_store
);

   localparam logic [ADDR_W-1:0] ADDR_LSB = ADDR_W'(1);

   logic [N_REQ-1:0]             req;
   logic [N_REQ-1:0]             we;
   logic [N_REQ-1:0][ADDR_W-1:0] addr;
   logic [N_REQ-1:0][DATA_W-1:0] wdata;
   logic [N_REQ-1:0]             hazard;
   logic [N_REQ-1:0]             blocked;
   logic [N_REQ-1:0]             eligible;
   logic [N_REQ-1:0]             gnt;
   logic [N_REQ-1:0]             load_gnt;
   logic                         gnt_id;
   logic                         store_gnt;

   logic                         en_q;
   req_id_e                      last_q;
   logic                         wr_valid_q;
   logic [ADDR_W-1:0]            wr_addr_q;
   logic [DATA_W-1:0]            wr_data_q;
   logic [ADDR_W-1:0]            rd_addr_q;
   logic [ADDR_W-1:0]            rd_addr;
   logic [DATA_W-1:0]            load_data;
   logic [N_REQ-1:0][DATA_W-1:0] rdata_q;
   state_e                       state_q [N_REQ];
   state_e                       state_d [N_REQ];

   assign req   = {dma_req, core_req};
   assign we    = {dma_we, core_we};
   assign addr  = {dma_addr, core_addr};
   assign wdata = {dma_wdata, core_wdata};

   // A load hazards when it targets the address the write stage commits this cycle.
   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         hazard[i] = req[i] && !we[i] && wr_valid_q && (addr[i] == wr_addr_q);
      end
   end

`ifdef DMEM_ARB_FWD_EN
   assign blocked = '0;
`else
   assign blocked = hazard;
`endif

   // en_q holds grants off until the first clock edge after reset release.
   assign eligible = en_q ? (req & ~blocked) : '0;

   rr_arb2 u_rr_arb2 (
      .req  (eligible),
      .last (last_q == REQ_DMA),
      .gnt  (gnt)
   );

   assign gnt_id    = gnt[REQ_DMA];
   assign load_gnt  = gnt & ~we;
   assign store_gnt = |(gnt & we);

   // Idle read address holds, but is steered off the committing store address.
   always_comb begin
      rd_addr = rd_addr_q;
      if (wr_valid_q && (rd_addr_q == wr_addr_q)) begin
         rd_addr = wr_addr_q ^ ADDR_LSB;
      end
      if (|load_gnt) begin
         rd_addr = addr[gnt_id];
`ifdef DMEM_ARB_FWD_EN
         if (hazard[gnt_id]) begin
            rd_addr = wr_addr_q ^ ADDR_LSB;
         end
`endif
      end
   end

   always_comb begin
      load_data = mem_rd_data;
`ifdef DMEM_ARB_FWD_EN
      if (hazard[gnt_id]) begin
         load_data = wr_data_q;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         en_q       <= 1'b0;
         last_q     <= REQ_DMA;
         wr_valid_q <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         rd_addr_q  <= '0;
         rdata_q    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         en_q       <= 1'b1;
         rd_addr_q  <= rd_addr;
         wr_valid_q <= store_gnt;
         if (|gnt) begin
            last_q <= gnt_id ? REQ_DMA : REQ_CORE;
         end
         if (store_gnt) begin
            wr_addr_q <= addr[gnt_id];
            wr_data_q <= wdata[gnt_id];
         end
         for (int i = 0; i < N_REQ; i++) begin
            if (load_gnt[i]) begin
               rdata_q[i] <= load_data;
            end
         end
      end
   end

   // Per-requester load tracker; RESP is the single rvalid cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REQ; i++) begin
            state_q[i] <= IDLE;
         end
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            state_q[i] <= state_d[i];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++) begin
         state_d[i] = state_q[i];
         case (state_q[i])
            IDLE, RESP: begin
               if (load_gnt[i]) begin
                  state_d[i] = RESP;
               end else if (req[i] && blocked[i]) begin
                  state_d[i] = STALL;
               end else begin
                  state_d[i] = IDLE;
               end
            end
            STALL: begin
               if (load_gnt[i]) begin
                  state_d[i] = RESP;
               end else if (!req[i]) begin
                  state_d[i] = IDLE;
               end
            end
            default: state_d[i] = IDLE;
         endcase
      end
   end

   assign core_gnt    = gnt[REQ_CORE];
   assign dma_gnt     = gnt[REQ_DMA];
   assign core_rvalid = (state_q[REQ_CORE] == RESP);
   assign dma_rvalid  = (state_q[REQ_DMA] == RESP);
   assign core_rdata  = rdata_q[REQ_CORE];
   assign dma_rdata   = rdata_q[REQ_DMA];

   assign mem_rd_addr = rd_addr;
   assign mem_wr_addr = wr_addr_q;
   assign mem_wr_data = wr_data_q;
   assign mem_store   = wr_valid_q;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed table, corner sequences and
// a randomized run against a rule-level model. Honours DMEM_ARB_FWD_EN.
module tb_dmem_port_arbiter;

`ifdef DMEM_ARB_FWD_EN
   localparam bit FWD = 1'b1;
`else
   localparam bit FWD = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       core_req, core_we, dma_req, dma_we;
   logic [7:0] core_addr, core_wdata, dma_addr, dma_wdata;
   logic       core_gnt, core_rvalid, dma_gnt, dma_rvalid;
   logic [7:0] core_rdata, dma_rdata;
   logic [7:0] mem_rd_addr, mem_rd_data, mem_wr_addr, mem_wr_data;
   logic       mem_store;

   logic [7:0] mem [256];
   logic [7:0] ref_mem [256];
   int         n_checks = 0;
   int         n_fail = 0;
   bit         mon_en = 1'b0;

   typedef struct {
      logic       c_req;
      logic [7:0] c_addr;
      logic       d_req;
      logic [7:0] d_addr;
      logic       e_cg;
      logic       e_dg;
   } vec_t;
   vec_t tbl [12];

   dmem_port_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .core_req    (core_req),
      .core_we     (core_we),
      .core_addr   (core_addr),
      .core_wdata  (core_wdata),
      .core_gnt    (core_gnt),
      .core_rvalid (core_rvalid),
      .core_rdata  (core_rdata),
      .dma_req     (dma_req),
      .dma_we      (dma_we),
      .dma_addr    (dma_addr),
      .dma_wdata   (dma_wdata),
      .dma_gnt     (dma_gnt),
      .dma_rvalid  (dma_rvalid),
      .dma_rdata   (dma_rdata),
      .mem_rd_addr (mem_rd_addr),
      .mem_rd_data (mem_rd_data),
      .mem_wr_addr (mem_wr_addr),
      .mem_wr_data (mem_wr_data),
      .mem_store   (mem_store)
   );

   always #5 clk = ~clk;

   assign mem_rd_data = mem[mem_rd_addr];
   always @(posedge clk) if (mem_store) mem[mem_wr_addr] = mem_wr_data;

   function automatic logic [7:0] pat(input logic [7:0] a);
      return a * 8'd3 + 8'd1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [7:0] ca, input logic [7:0] cd,
                        input logic dr, input logic dw, input logic [7:0] da, input logic [7:0] dd);
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      dma_req  = dr; dma_we  = dw; dma_addr  = da; dma_wdata  = dd;
   endtask

   task automatic idle();
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cycle();
   endtask

   // Invariants checked on every cycle outside reset.
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         check("one_grant", 32'(core_gnt & dma_gnt), 32'h0);
         if (mem_store) check("rd_wr_collision", 32'(mem_rd_addr == mem_wr_addr), 32'h0);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic       prev_cg, prev_dg;
      logic [7:0] prev_ca, prev_da, exp_rd;
      bit         rq [2];
      bit         rw [2];
      bit         haz [2];
      bit         el [2];
      bit         erv [2];
      logic [7:0] ra [2];
      logic [7:0] rdv [2];
      logic [7:0] erd [2];
      bit         m_wv;
      logic [7:0] m_wa, m_wd;
      int         m_last, win;

      for (int i = 0; i < 256; i++) mem[i] = pat(8'(i));
      for (int i = 0; i < 256; i++) ref_mem[i] = pat(8'(i));
      mem[8'h10] = 8'hA5;

      tbl[0]  = '{1'b1, 8'h40, 1'b1, 8'h50, 1'b1, 1'b0};
      tbl[1]  = '{1'b1, 8'h41, 1'b1, 8'h50, 1'b0, 1'b1};
      tbl[2]  = '{1'b1, 8'h41, 1'b1, 8'h51, 1'b1, 1'b0};
      tbl[3]  = '{1'b1, 8'h42, 1'b1, 8'h51, 1'b0, 1'b1};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
      tbl[5]  = '{1'b1, 8'h43, 1'b1, 8'h52, 1'b1, 1'b0};
      tbl[6]  = '{1'b0, 8'h00, 1'b1, 8'h52, 1'b0, 1'b1};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 8'h53, 1'b0, 1'b1};
      tbl[8]  = '{1'b1, 8'h44, 1'b1, 8'h54, 1'b1, 1'b0};
      tbl[9]  = '{1'b1, 8'h45, 1'b0, 8'h00, 1'b1, 1'b0};
      tbl[10] = '{1'b1, 8'h46, 1'b1, 8'h54, 1'b0, 1'b1};
      tbl[11] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

      // Reset values, with both requesters already asking.
      drive(1'b1, 1'b0, 8'h10, 8'h00, 1'b1, 1'b0, 8'h50, 8'h00);
      #12;
      check("rst_core_gnt", 32'(core_gnt), 32'h0);
      check("rst_dma_gnt", 32'(dma_gnt), 32'h0);
      check("rst_core_rvalid", 32'(core_rvalid), 32'h0);
      check("rst_dma_rvalid", 32'(dma_rvalid), 32'h0);
      check("rst_core_rdata", 32'(core_rdata), 32'h0);
      check("rst_dma_rdata", 32'(dma_rdata), 32'h0);
      check("rst_mem_store", 32'(mem_store), 32'h0);
      check("rst_mem_rd_addr", 32'(mem_rd_addr), 32'h0);
      check("rst_mem_wr_addr", 32'(mem_wr_addr), 32'h0);
      check("rst_mem_wr_data", 32'(mem_wr_data), 32'h0);

      // Core load 0x10 -> rvalid one cycle later with 0xA5.
      @(negedge clk);
      rst_n = 1'b1;
      dma_req = 1'b0;
      mon_en = 1'b1;
      #1;
      check("gnt_before_first_edge", 32'(core_gnt), 32'h0);
      next_cycle();
      @(negedge clk);
      check("ld10_gnt", 32'(core_gnt), 32'h1);
      check("ld10_rd_addr", 32'(mem_rd_addr), 32'h10);
      check("ld10_rvalid_c0", 32'(core_rvalid), 32'h0);
      next_cycle();
      idle();
      @(negedge clk);
      check("ld10_rvalid_c1", 32'(core_rvalid), 32'h1);
      check("ld10_rdata", 32'(core_rdata), 32'hA5);
      next_cycle();
      @(negedge clk);
      check("ld10_rvalid_c2", 32'(core_rvalid), 32'h0);

      // Table: round-robin alternation, pointer hold, idle read-address hold.
      do_reset();
      prev_cg = 1'b0; prev_dg = 1'b0; prev_ca = 8'h00; prev_da = 8'h00; exp_rd = 8'h00;
      for (int i = 0; i < 12; i++) begin
         drive(tbl[i].c_req, 1'b0, tbl[i].c_addr, 8'h00, tbl[i].d_req, 1'b0, tbl[i].d_addr, 8'h00);
         @(negedge clk);
         check($sformatf("tbl%0d_core_gnt", i), 32'(core_gnt), 32'(tbl[i].e_cg));
         check($sformatf("tbl%0d_dma_gnt", i), 32'(dma_gnt), 32'(tbl[i].e_dg));
         if (tbl[i].e_cg) exp_rd = tbl[i].c_addr;
         else if (tbl[i].e_dg) exp_rd = tbl[i].d_addr;
         check($sformatf("tbl%0d_rd_addr", i), 32'(mem_rd_addr), 32'(exp_rd));
         check($sformatf("tbl%0d_core_rvalid", i), 32'(core_rvalid), 32'(prev_cg));
         check($sformatf("tbl%0d_dma_rvalid", i), 32'(dma_rvalid), 32'(prev_dg));
         if (prev_cg) check($sformatf("tbl%0d_core_rdata", i), 32'(core_rdata), 32'(pat(prev_ca)));
         if (prev_dg) check($sformatf("tbl%0d_dma_rdata", i), 32'(dma_rdata), 32'(pat(prev_da)));
         check($sformatf("tbl%0d_mem_store", i), 32'(mem_store), 32'h0);
         prev_cg = tbl[i].e_cg; prev_dg = tbl[i].e_dg;
         prev_ca = tbl[i].c_addr; prev_da = tbl[i].d_addr;
         next_cycle();
      end

      // DMA store 0x20<=0x3C, then core load 0x20.
      drive(1'b0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1, 8'h20, 8'h3C);
      @(negedge clk);
      check("haz_dma_store_gnt", 32'(dma_gnt), 32'h1);
      next_cycle();
      drive(1'b1, 1'b0, 8'h20, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      check("haz_mem_store", 32'(mem_store), 32'h1);
      check("haz_wr_addr", 32'(mem_wr_addr), 32'h20);
      check("haz_wr_data", 32'(mem_wr_data), 32'h3C);
      if (FWD) begin
         check("fwd_core_gnt", 32'(core_gnt), 32'h1);
         check("fwd_rd_addr", 32'(mem_rd_addr), 32'h21);
      end else begin
         check("stall_core_gnt", 32'(core_gnt), 32'h0);
         next_cycle();
         @(negedge clk);
         check("stall_rvalid", 32'(core_rvalid), 32'h0);
         check("after_stall_gnt", 32'(core_gnt), 32'h1);
         check("after_stall_rd_addr", 32'(mem_rd_addr), 32'h20);
      end
      next_cycle();
      idle();
      @(negedge clk);
      check("haz_rvalid", 32'(core_rvalid), 32'h1);
      check("haz_rdata", 32'(core_rdata), 32'h3C);
      next_cycle();

      // Four back-to-back core stores to 0x00..0x03.
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 1'b1, 8'(i), 8'hD0 + 8'(i), 1'b0, 1'b0, 8'h00, 8'h00);
         @(negedge clk);
         check($sformatf("b2b%0d_gnt", i), 32'(core_gnt), 32'h1);
         if (i > 0) begin
            check($sformatf("b2b%0d_store", i), 32'(mem_store), 32'h1);
            check($sformatf("b2b%0d_wr_addr", i), 32'(mem_wr_addr), 32'(i - 1));
            check($sformatf("b2b%0d_wr_data", i), 32'(mem_wr_data), 32'hD0 + 32'(i - 1));
         end
         next_cycle();
      end
      idle();
      @(negedge clk);
      check("b2b4_store", 32'(mem_store), 32'h1);
      check("b2b4_wr_addr", 32'(mem_wr_addr), 32'h03);
      check("b2b4_wr_data", 32'(mem_wr_data), 32'hD3);
      next_cycle();
      drive(1'b1, 1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      check("b2b_idle_store", 32'(mem_store), 32'h0);
      check("b2b_ld_gnt", 32'(core_gnt), 32'h1);
      next_cycle();
      idle();
      @(negedge clk);
      check("b2b_ld_rdata", 32'(core_rdata), 32'hD2);
      next_cycle();

      // Reset while a store sits in the write stage.
      drive(1'b1, 1'b1, 8'h30, 8'h77, 1'b0, 1'b0, 8'h00, 8'h00);
      @(negedge clk);
      check("rstw_gnt", 32'(core_gnt), 32'h1);
      next_cycle();
      idle();
      check("rstw_pending", 32'(mem_store), 32'h1);
      #1;
      rst_n = 1'b0;
      #1;
      check("rstw_store_drop", 32'(mem_store), 32'h0);
      check("rstw_wr_addr", 32'(mem_wr_addr), 32'h0);
      check("rstw_wr_data", 32'(mem_wr_data), 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      drive(1'b1, 1'b0, 8'h30, 8'h00, 1'b0, 1'b0, 8'h00, 8'h00);
      #1;
      check("rstw_mem_kept", 32'(mem[8'h30]), 32'h91);
      check("rstw_gnt_wait", 32'(core_gnt), 32'h0);
      next_cycle();
      @(negedge clk);
      check("rstw_resume_gnt", 32'(core_gnt), 32'h1);
      check("rstw_resume_rd_addr", 32'(mem_rd_addr), 32'h30);
      next_cycle();
      idle();
      @(negedge clk);
      check("rstw_resume_rvalid", 32'(core_rvalid), 32'h1);
      check("rstw_resume_rdata", 32'(core_rdata), 32'h91);

      // Randomized traffic on a tight address window against the rule model.
      do_reset();
      for (int r = 0; r < 2; r++) begin
         rq[r] = 1'b0; rw[r] = 1'b0; ra[r] = 8'h00; rdv[r] = 8'h00; erv[r] = 1'b0; erd[r] = 8'h00;
      end
      m_wv = 1'b0; m_wa = 8'h00; m_wd = 8'h00; m_last = 1;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int r = 0; r < 2; r++) begin
            if (!rq[r] && $urandom_range(0, 3) != 0) begin
               rq[r]  = 1'b1;
               rw[r]  = 1'($urandom_range(0, 1));
               ra[r]  = 8'h60 + 8'($urandom_range(0, 3));
               rdv[r] = 8'($urandom);
            end
         end
         drive(rq[0], rw[0], ra[0], rdv[0], rq[1], rw[1], ra[1], rdv[1]);
         @(negedge clk);
         for (int r = 0; r < 2; r++) begin
            haz[r] = rq[r] && !rw[r] && m_wv && (ra[r] == m_wa);
            el[r]  = rq[r] && (FWD || !haz[r]);
         end
         win = -1;
         if (el[0] && el[1]) win = 1 - m_last;
         else if (el[0]) win = 0;
         else if (el[1]) win = 1;
         check("rnd_core_gnt", 32'(core_gnt), 32'(win == 0));
         check("rnd_dma_gnt", 32'(dma_gnt), 32'(win == 1));
         check("rnd_core_rvalid", 32'(core_rvalid), 32'(erv[0]));
         check("rnd_dma_rvalid", 32'(dma_rvalid), 32'(erv[1]));
         if (erv[0]) check("rnd_core_rdata", 32'(core_rdata), 32'(erd[0]));
         if (erv[1]) check("rnd_dma_rdata", 32'(dma_rdata), 32'(erd[1]));
         check("rnd_mem_store", 32'(mem_store), 32'(m_wv));
         if (m_wv) begin
            check("rnd_wr_addr", 32'(mem_wr_addr), 32'(m_wa));
            check("rnd_wr_data", 32'(mem_wr_data), 32'(m_wd));
         end
         for (int r = 0; r < 2; r++) begin
            erv[r] = (win == r) && !rw[r];
            if (erv[r]) begin
               erd[r] = haz[r] ? m_wd : ref_mem[ra[r]];
               check("rnd_rd_addr", 32'(mem_rd_addr), 32'(haz[r] ? (m_wa ^ 8'h01) : ra[r]));
            end
         end
         if (m_wv) ref_mem[m_wa] = m_wd;
         m_wv = 1'b0;
         if (win >= 0) begin
            if (rw[win]) begin
               m_wv = 1'b1;
               m_wa = ra[win];
               m_wd = rdv[win];
            end
            m_last  = win;
            rq[win] = 1'b0;
         end
         next_cycle();
      end
      idle();
      repeat (3) next_cycle();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
